// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared widths, func3 codes, state encoding and helpers for the RV64M sequencer
package muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int IDX_W = $clog2(XLEN);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] N_DWORD = CNT_W'(64);
  localparam logic [CNT_W-1:0] N_WORD  = CNT_W'(32);

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// rtl/muldiv_iter_step.sv - one MSB-first iteration: shift-add multiply or restoring divide step
module muldiv_iter_step
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic              in_bit,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_next
);

  // Divide layout: acc = {partial remainder, quotient bits shifted in from the right}.
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] rem_sub;
  logic            fits;

  always_comb begin
    rem_shift = {acc[2*XLEN-1:XLEN], in_bit};
    rem_sub   = rem_shift[XLEN-1:0] - opb;
    fits      = rem_shift >= {1'b0, opb};
    acc_next  = '0;
    if (is_div) begin
      if (fits) begin
        acc_next = {rem_sub, acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {acc[2*XLEN-2:0], 1'b0} + (in_bit ? {{XLEN{1'b0}}, opb} : {(2*XLEN){1'b0}});
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV64M multiply/divide sequencer that stalls execute
// MULDIV_FAST_MUL_EN: multiplies use a single-cycle array multiply in CALC; divides stay iterative.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_v,
  input  logic [2:0]      req_func3,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done_v,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  state_t            state, state_nxt;
  logic [2:0]        f3;
  logic              word;
  logic [XLEN-1:0]   opa, opb;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r;
  logic              stall_c;

  logic is_div, rem_op, sgn_a, sgn_b;
  assign is_div = f3[2];
  assign rem_op = f3[1];
  assign sgn_a  = (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
                  (f3 == F3_DIV) || (f3 == F3_REM);
  assign sgn_b  = (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);

  // Operand conditioning and RISC-V special-case detection, used in PREP.
  logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, div_w, spec_res;
  logic             a_neg, b_neg, div_zero, div_ovf, no_enc, special;
  logic [CNT_W-1:0] cnt_init;

  always_comb begin
    a_ext = opa;
    b_ext = opb;
    if (word) begin
      a_ext = sgn_a ? sext32(opa[31:0]) : {{(XLEN-32){1'b0}}, opa[31:0]};
      b_ext = sgn_b ? sext32(opb[31:0]) : {{(XLEN-32){1'b0}}, opb[31:0]};
    end
    div_w    = word ? sext32(opa[31:0]) : opa;
    a_neg    = sgn_a & a_ext[XLEN-1];
    b_neg    = sgn_b & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && sgn_b && (a_ext == (word ? MIN_W : MIN_D)) && (b_ext == '1);
    no_enc   = word && ((f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU));
    special  = div_zero | div_ovf | no_enc;
    if (no_enc) begin
      spec_res = '0;
    end else if (div_zero) begin
      spec_res = rem_op ? div_w : '1;
    end else begin
      spec_res = rem_op ? '0 : div_w;
    end
    cnt_init = word ? N_WORD : N_DWORD;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) begin
      cnt_init = CNT_W'(1);
    end
`endif
  end

  logic [IDX_W-1:0]  bit_idx;
  logic [2*XLEN-1:0] step_acc, calc_acc;
  assign bit_idx = cnt[IDX_W-1:0] - IDX_W'(1);

  muldiv_iter_step u_step (
    .is_div   (is_div),
    .in_bit   (opa[bit_idx]),
    .acc      (acc),
    .opb      (opb),
    .acc_next (step_acc)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign calc_acc = is_div ? step_acc : ({{XLEN{1'b0}}, opa} * {{XLEN{1'b0}}, opb});
`else
  assign calc_acc = step_acc;
`endif

  // Sign correction and half/quotient/remainder selection, used in FIX.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_raw, fix_res;

  always_comb begin
    prod    = neg_q ? -acc : acc;
    quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_raw = is_div ? (rem_op ? rem : quo)
                     : ((f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    fix_res = word ? sext32(fix_raw[31:0]) : fix_raw;
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_c = req_v & ~flush;
        if (req_v) state_nxt = ST_PREP;
      end
      ST_PREP: begin
        stall_c   = 1'b1;
        state_nxt = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        stall_c = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        stall_c   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Reset gates the stall so a requester still holding req_v sees it drop immediately.
  assign stall  = stall_c & rst_n;
  assign busy   = (state != ST_IDLE);
  assign done_v = (state == ST_DONE) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      f3     <= '0;
      word   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (!flush) begin
        case (state)
          ST_IDLE: begin
            if (req_v) begin
              f3   <= req_func3;
              word <= req_word;
              opa  <= req_a;
              opb  <= req_b;
            end
          end
          ST_PREP: begin
            opa   <= a_mag;
            opb   <= b_mag;
            acc   <= '0;
            cnt   <= cnt_init;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special) result <= spec_res;
          end
          ST_CALC: begin
            acc <= calc_acc;
            cnt <= cnt - CNT_W'(1);
          end
          ST_FIX:  result <= fix_res;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for RV64M multiply/divide ops. Replaces the single-cycle combinational M-extension path in the execute stage.
- Accepts one op from execute and raises a stall to hold the pipeline while a shift-add / restoring-divide datapath iterates.
- Presents the 64-bit result with a one-cycle done pulse, which execute latches into its MEM_ALU_RESULT register.

Parameters:
- XLEN, 64, operand/result width; word ops use the low 32 bits.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous reset, active-low
- REQ_V  in  1  M-ext op present in execute (opcode 0110011/0111011 with func7=0000001, EXE_V=1)
- REQ_FUNC3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- REQ_WORD  in  1  1 = W-variant (opcode 0111011)
- REQ_A  in  XLEN  rs1 operand
- REQ_B  in  XLEN  rs2 operand
- FLUSH  in  1  synchronous abort (branch redirect/exception)
- STALL  out  1  hold execute and upstream stages
- BUSY  out  1  op in flight (state != IDLE)
- DONE_V  out  1  one-cycle pulse, RESULT valid
- RESULT  out  XLEN  final result

Behaviour:
- Reset (RST_N=0, async): state IDLE; STALL=0, BUSY=0, DONE_V=0, RESULT=0; counter and working registers 0. Reset mid-operation aborts silently.
- States: IDLE, PREP, CALC, FIX, DONE.
  - IDLE: on REQ_V=1 and FLUSH=0, latch func3/word/operands, go to PREP.
  - PREP: compute operand magnitudes and result sign; detect special cases; load counter N (64, or 32 if word). Special case -> DONE, else -> CALC.
  - CALC: one iteration per cycle, counter decrements; at counter=1 -> FIX.
  - FIX: apply sign correction, select quotient/remainder/low/high half, sign-extend word results from bit 31 -> DONE.
  - DONE: DONE_V=1, RESULT driven -> IDLE.
- STALL = (state==IDLE & REQ_V & !FLUSH) | (state in PREP, CALC, FIX). STALL is low in DONE, so execute advances and captures RESULT that cycle.
- Requester holds REQ_* stable while STALL=1. REQ_V is ignored outside IDLE.
- Latency from accept cycle 0: DONE_V at cycle 67 (64-bit) or 35 (word); special cases at cycle 2.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*XLEN product.
  - Sign flags: MUL/MULH both signed, MULHSU A only, MULHU none; product negated in FIX if signs differ.
  - MUL returns low half, MULH* return high half.
- Divide: restoring, 1 quotient bit per cycle. Quotient sign = sA^sB; remainder sign = sA (signed ops only).
- Special cases (RISC-V rules), word ops on 32-bit values then sign-extended:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - REQ_WORD with func3 1..3 (no encoding): RESULT = 0 via special path.
- FLUSH: in any state, next state IDLE, DONE_V not asserted, RESULT holds previous value. FLUSH has priority over a new accept.
- RESULT holds its value until the next DONE.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: multiplies use a single-cycle 2*XLEN array multiply in CALC; mul latency fixed at DONE_V cycle 4. Divides unchanged.
  - Undefined: iterative multiply as above; no `*` operator is synthesized.

Decomposition:
- muldiv_pkg:
  - XLEN
  - func3 localparams (F3_MUL..F3_REMU)
  - state encoding (ST_IDLE..ST_DONE)
  - word-count constants (64/32)
- One sub-module: muldiv_iter_step, combinational single-iteration datapath (shift-add step or restoring subtract step) selected by a mul/div flag. The sequencer owns all registers.

Test Plan:
- DIVU A=100, B=7 -> RESULT=14 with DONE_V at cycle 67; REMU same operands -> 2; STALL high cycles 0..66, low at 67.
- DIV A=-7, B=2 -> 0xFFFFFFFFFFFFFFFD; REM -> 0xFFFFFFFFFFFFFFFF.
- DIVU B=0, A=0x1234 -> 0xFFFFFFFFFFFFFFFF at cycle 2; REMU B=0 -> 0x1234.
- DIVW A=0x80000000, B=0xFFFFFFFF -> 0xFFFFFFFF80000000 at cycle 2; REMW same -> 0.
- MULH A=B=-1 -> 0; MULHU A=B=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; MULW A=0x7FFFFFFF, B=2 -> 0xFFFFFFFFFFFFFFFE at cycle 35.
- FLUSH in CALC cycle 10 -> no DONE_V, IDLE next cycle, following DIVU 9/3 -> 3. RST_N low mid-CALC -> all outputs 0 immediately.
